// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and elaboration-time helpers for the configuration-chain loader.
package ccff_chain_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARKER,
        ST_LOAD,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [31:0] DEFAULT_MARKER = 32'h0000_00A5;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Width of a counter that must hold 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic bit_at(input logic [31:0] vec, input int idx);
        return |(vec & (32'h1 << idx));
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream (valid/ready) feeding the chain loader.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] bs_data;
    logic              bs_valid;
    logic              bs_ready;

    modport master (output bs_data, output bs_valid, input bs_ready);
    modport slave  (input bs_data, input bs_valid, output bs_ready);
endinterface

// File: rtl/ccff_chain_loader_word_serializer.sv
// Word buffer that turns accepted bitstream words into a bit stream, LSB first,
// refilling on the same edge its last bit leaves so words flow without bubbles.
module ccff_word_serializer
    import ccff_chain_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [WORD_W-1:0] word,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              shift,
    output logic              bit_out
);
    localparam int WORDS     = ceil_div(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = CHAIN_LEN - (WORDS - 1) * WORD_W;
    localparam int BW        = cnt_w(WORD_W);
    localparam int WCW       = cnt_w(WORDS);

    logic [WORD_W-1:0] data_q;
    logic [BW-1:0]     bits_q;
    logic [WCW-1:0]    words_q;
    logic              take;

    assign shift      = enable && (bits_q != '0);
    assign word_ready = enable && (words_q != '0) && (bits_q <= BW'(1));
    assign take       = word_valid && word_ready;
    assign bit_out    = data_q[0];

    // Only the valid low bits of the final word are counted, so its padding never shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_q <= '0;
            bits_q  <= '0;
            data_q  <= '0;
        end else if (clear) begin
            words_q <= WCW'(WORDS);
            bits_q  <= '0;
            data_q  <= '0;
        end else if (take) begin
            words_q <= words_q - WCW'(1);
            bits_q  <= (words_q == WCW'(1)) ? BW'(LAST_BITS) : BW'(WORD_W);
            data_q  <= word;
        end else if (shift) begin
            bits_q  <= bits_q - BW'(1);
            data_q  <= data_q >> 1;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain writer: shifts a marker then the bitstream into ccff_head and
// verifies the marker arrives at ccff_tail before releasing IO isolation.
module ccff_chain_loader
    import ccff_chain_loader_pkg::*;
#(
    parameter int          CHAIN_LEN  = 1000,
    parameter int          WORD_W     = 32,
    parameter int          MARKER_LEN = 8,
    parameter logic [31:0] MARKER     = DEFAULT_MARKER
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic                start,
    ccff_chain_loader_if.slave  bs,
    output logic                prog_clk_en,
    output logic                ccff_head,
    input  logic                ccff_tail,
    output logic                IO_ISOL_N,
    output logic                busy,
    output logic                done,
    output logic                error
);
    localparam int TOTAL = CHAIN_LEN + MARKER_LEN;
    localparam int KW    = cnt_w(TOTAL);

    state_t        state_q, state_d;
    logic [KW-1:0] k_q;
    logic          mism_q;
    logic          launch;
    logic          ser_shift;
    logic          ser_bit;
    logic          shift_en;
    logic          last_shift;
    logic          tail_bad;

    assign launch     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_ERROR));
    assign shift_en   = (state_q == ST_MARKER) || ser_shift;
    assign last_shift = shift_en && (k_q == KW'(TOTAL - 1));
    assign prog_clk_en = shift_en;

    // Once k reaches CHAIN_LEN the marker bits shifted first must be leaving the tail.
    assign tail_bad = shift_en && (int'(k_q) >= CHAIN_LEN) &&
                      (ccff_tail != bit_at(MARKER, int'(k_q) - CHAIN_LEN));

    ccff_word_serializer #(
        .WORD_W    (WORD_W),
        .CHAIN_LEN (CHAIN_LEN)
    ) u_ser (
        .clk        (prog_clk),
        .rst        (prog_reset),
        .clear      (launch),
        .enable     (state_q == ST_LOAD),
        .word       (bs.bs_data),
        .word_valid (bs.bs_valid),
        .word_ready (bs.bs_ready),
        .shift      (ser_shift),
        .bit_out    (ser_bit)
    );

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                k_q    <= '0;
                mism_q <= 1'b0;
            end else if (shift_en) begin
                k_q    <= k_q + KW'(1);
                mism_q <= mism_q | tail_bad;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_MARKER;
            ST_MARKER: if (k_q == KW'(MARKER_LEN - 1)) state_d = ST_LOAD;
            ST_LOAD: begin
                if (last_shift) state_d = (mism_q || tail_bad) ? ST_ERROR : ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ccff_head = 1'b0;
        IO_ISOL_N = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            ST_MARKER: begin
                ccff_head = bit_at(MARKER, int'(k_q));
                busy      = 1'b1;
            end
            ST_LOAD: begin
                ccff_head = ser_bit;
                busy      = 1'b1;
            end
            ST_DONE: begin
                IO_ISOL_N = 1'b1;
                done      = 1'b1;
            end
            ST_ERROR: error = 1'b1;
            default: ;
        endcase
    end

endmodule
